rf_writeback: RTL and testbench

//  Writeback stage feeding the Z80 micro-op register file's single write port (Wr_id/Wr_data/Fmask/F_data).

---
 rtl/rf_writeback_pkg.sv | 89 ++++++++
 rtl/rf_writeback_load_fifo.sv | 60 ++++++
 rtl/rf_writeback.sv | 155 +++++++++++++++
 tb/tb_rf_writeback.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rf_writeback_pkg.sv
// rtl/rf_writeback_pkg.sv - register ids, byte indices and id-to-byte-mask map for the writeback stage
package rf_writeback_pkg;

  localparam int WB_NBYTES = 28;
  localparam int ID_W      = 5;
  localparam int DATA_W    = 16;

  typedef enum logic [ID_W-1:0] {
    rR0  = 5'd0,  rA   = 5'd1,  rF   = 5'd2,  rB   = 5'd3,
    rC   = 5'd4,  rD   = 5'd5,  rE   = 5'd6,  rH   = 5'd7,
    rL   = 5'd8,  rI   = 5'd9,  rR   = 5'd10, rT0  = 5'd11,
    rT1  = 5'd12, rT2  = 5'd13, rT3  = 5'd14, rAF  = 5'd15,
    rBC  = 5'd16, rDE  = 5'd17, rHL  = 5'd18, rSP  = 5'd19,
    rIX  = 5'd20, rIY  = 5'd21, rAF2 = 5'd22, rBC2 = 5'd23,
    rDE2 = 5'd24, rHL2 = 5'd25, rT01 = 5'd26, rT23 = 5'd27
  } wb_reg_id_e;

  localparam int B_A    = 0;
  localparam int B_F    = 1;
  localparam int B_B    = 2;
  localparam int B_C    = 3;
  localparam int B_D    = 4;
  localparam int B_E    = 5;
  localparam int B_H    = 6;
  localparam int B_L    = 7;
  localparam int B_I    = 8;
  localparam int B_R    = 9;
  localparam int B_T0   = 10;
  localparam int B_T1   = 11;
  localparam int B_T2   = 12;
  localparam int B_T3   = 13;
  localparam int B_SPH  = 14;
  localparam int B_SPL  = 15;
  localparam int B_IXH  = 16;
  localparam int B_IXL  = 17;
  localparam int B_IYH  = 18;
  localparam int B_IYL  = 19;
  localparam int B_AF2H = 20;
  localparam int B_AF2L = 21;
  localparam int B_BC2H = 22;
  localparam int B_BC2L = 23;
  localparam int B_DE2H = 24;
  localparam int B_DE2L = 25;
  localparam int B_HL2H = 26;
  localparam int B_HL2L = 27;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } ld_entry_t;

  // rR0 and unassigned ids touch no byte, so they never mark or test busy.
  function automatic logic [WB_NBYTES-1:0] reg2mask(input logic [ID_W-1:0] id);
    logic [WB_NBYTES-1:0] m;
    m = '0;
    case (wb_reg_id_e'(id))
      rA:   m[B_A]  = 1'b1;
      rF:   m[B_F]  = 1'b1;
      rB:   m[B_B]  = 1'b1;
      rC:   m[B_C]  = 1'b1;
      rD:   m[B_D]  = 1'b1;
      rE:   m[B_E]  = 1'b1;
      rH:   m[B_H]  = 1'b1;
      rL:   m[B_L]  = 1'b1;
      rI:   m[B_I]  = 1'b1;
      rR:   m[B_R]  = 1'b1;
      rT0:  m[B_T0] = 1'b1;
      rT1:  m[B_T1] = 1'b1;
      rT2:  m[B_T2] = 1'b1;
      rT3:  m[B_T3] = 1'b1;
      rAF:  begin m[B_A]    = 1'b1; m[B_F]    = 1'b1; end
      rBC:  begin m[B_B]    = 1'b1; m[B_C]    = 1'b1; end
      rDE:  begin m[B_D]    = 1'b1; m[B_E]    = 1'b1; end
      rHL:  begin m[B_H]    = 1'b1; m[B_L]    = 1'b1; end
      rSP:  begin m[B_SPH]  = 1'b1; m[B_SPL]  = 1'b1; end
      rIX:  begin m[B_IXH]  = 1'b1; m[B_IXL]  = 1'b1; end
      rIY:  begin m[B_IYH]  = 1'b1; m[B_IYL]  = 1'b1; end
      rAF2: begin m[B_AF2H] = 1'b1; m[B_AF2L] = 1'b1; end
      rBC2: begin m[B_BC2H] = 1'b1; m[B_BC2L] = 1'b1; end
      rDE2: begin m[B_DE2H] = 1'b1; m[B_DE2L] = 1'b1; end
      rHL2: begin m[B_HL2H] = 1'b1; m[B_HL2L] = 1'b1; end
      rT01: begin m[B_T0]   = 1'b1; m[B_T1]   = 1'b1; end
      rT23: begin m[B_T2]   = 1'b1; m[B_T3]   = 1'b1; end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rf_writeback_load_fifo.sv
// rtl/rf_writeback_load_fifo.sv - load return buffer (wb_load_fifo), power-of-2 depth, head visible combinationally
module wb_load_fifo
  import rf_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      CLK,
  input  logic      RST_N,
  input  logic      push,
  input  logic      pop,
  input  ld_entry_t din,
  output logic      full,
  output logic      empty,
  output ld_entry_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ld_entry_t       mem_q [DEPTH];
  ld_entry_t       mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     cnt_q, cnt_d;

  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/rf_writeback.sv
// rtl/rf_writeback.sv - RF writeback arbiter: ALU/load merge, anti-starvation, byte busy scoreboard
// Optional WB_STATS_EN adds DEBUG_WB_stats = {alu_wr_cnt, ld_wr_cnt, starve_cnt}.
module rf_writeback
  import rf_writeback_pkg::*;
#(
  parameter int LD_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              alu_valid,
  input  logic [ID_W-1:0]   alu_wr_id,
  input  logic [DATA_W-1:0] alu_wr_data,
  input  logic [7:0]        alu_fmask,
  input  logic [7:0]        alu_fdata,
  output logic              alu_stall,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ID_W-1:0]   ld_wr_id,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              iss_valid,
  input  logic [ID_W-1:0]   iss_dst_id,
  input  logic [ID_W-1:0]   q0_id,
  input  logic [ID_W-1:0]   q1_id,
  input  logic [ID_W-1:0]   qd_id,
  output logic              hazard,
  output logic [ID_W-1:0]   Wr_id,
  output logic [DATA_W-1:0] Wr_data,
  output logic [7:0]        Fmask,
  output logic [7:0]        F_data
`ifdef WB_STATS_EN
  ,
  output logic [47:0]       DEBUG_WB_stats
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  ld_entry_t         fifo_head, ld_in;
  logic              ld_acc, alu_gnt, head_gnt, byp_gnt, ld_gnt;
  logic [ID_W-1:0]   ld_gnt_id;
  logic [WB_NBYTES-1:0] set_mask, clr_mask;

  logic [SW-1:0]        starve_q, starve_d;
  logic [WB_NBYTES-1:0] busy_q, busy_d;
  logic [ID_W-1:0]      wr_id_q, wr_id_d;
  logic [DATA_W-1:0]    wr_data_q, wr_data_d;
  logic [7:0]           fmask_q, fmask_d;
  logic [7:0]           fdata_q, fdata_d;

  assign ld_in.id   = ld_wr_id;
  assign ld_in.data = ld_data;

  wb_load_fifo #(.DEPTH(LD_FIFO_DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (ld_in),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Priority: ALU, then buffered head, then an incoming load straight through.
  assign ld_ready  = RST_N && !fifo_full;
  assign ld_acc    = ld_valid && ld_ready;
  assign alu_stall = RST_N && !fifo_empty && (starve_q == SW'(STARVE_LIMIT));
  assign alu_gnt   = alu_valid && !alu_stall;
  assign head_gnt  = !alu_gnt && !fifo_empty;
  assign byp_gnt   = !alu_gnt && fifo_empty && ld_acc;
  assign ld_gnt    = head_gnt || byp_gnt;
  assign ld_gnt_id = head_gnt ? fifo_head.id : ld_wr_id;
  assign fifo_pop  = head_gnt;
  assign fifo_push = ld_acc && !byp_gnt;

  assign set_mask = iss_valid ? reg2mask(iss_dst_id) : '0;
  assign clr_mask = ld_gnt ? reg2mask(ld_gnt_id) : '0;
  assign hazard   = |(busy_q & (reg2mask(q0_id) | reg2mask(q1_id) | reg2mask(qd_id)));

  always_comb begin
    starve_d  = starve_q;
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    wr_id_d   = rR0;
    wr_data_d = '0;
    fmask_d   = '0;
    fdata_d   = '0;
    if (ld_gnt || fifo_empty) starve_d = '0;
    else if (alu_gnt)         starve_d = starve_q + SW'(1);
    if (alu_gnt) begin
      wr_id_d   = alu_wr_id;
      wr_data_d = alu_wr_data;
      fmask_d   = alu_fmask;
      fdata_d   = alu_fdata;
    end else if (head_gnt) begin
      wr_id_d   = fifo_head.id;
      wr_data_d = fifo_head.data;
    end else if (byp_gnt) begin
      wr_id_d   = ld_wr_id;
      wr_data_d = ld_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      starve_q  <= '0;
      busy_q    <= '0;
      wr_id_q   <= rR0;
      wr_data_q <= '0;
      fmask_q   <= '0;
      fdata_q   <= '0;
    end else begin
      starve_q  <= starve_d;
      busy_q    <= busy_d;
      wr_id_q   <= wr_id_d;
      wr_data_q <= wr_data_d;
      fmask_q   <= fmask_d;
      fdata_q   <= fdata_d;
    end
  end

  assign Wr_id   = wr_id_q;
  assign Wr_data = wr_data_q;
  assign Fmask   = fmask_q;
  assign F_data  = fdata_q;

  a_issue_to_busy: assert property (@(posedge CLK) disable iff (!RST_N)
    !(iss_valid && |(busy_q & set_mask)));

`ifdef WB_STATS_EN
  logic [15:0] alu_cnt_q, alu_cnt_d, ld_cnt_q, ld_cnt_d, stv_cnt_q, stv_cnt_d;

  always_comb begin
    alu_cnt_d = alu_gnt   ? alu_cnt_q + 16'd1 : alu_cnt_q;
    ld_cnt_d  = ld_gnt    ? ld_cnt_q  + 16'd1 : ld_cnt_q;
    stv_cnt_d = alu_stall ? stv_cnt_q + 16'd1 : stv_cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      alu_cnt_q <= '0;
      ld_cnt_q  <= '0;
      stv_cnt_q <= '0;
    end else begin
      alu_cnt_q <= alu_cnt_d;
      ld_cnt_q  <= ld_cnt_d;
      stv_cnt_q <= stv_cnt_d;
    end
  end

  assign DEBUG_WB_stats = {alu_cnt_q, ld_cnt_q, stv_cnt_q};
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// tb/tb_rf_writeback.sv - directed self-checking bench for rf_writeback
module tb_rf_writeback;

  localparam logic [4:0] ID_R0 = 5'd0, ID_A = 5'd1, ID_B = 5'd3, ID_C = 5'd4, ID_D = 5'd5,
                         ID_E = 5'd6, ID_H = 5'd7, ID_BC = 5'd16, ID_HL = 5'd18;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        alu_valid, ld_valid, iss_valid;
  logic [4:0]  alu_wr_id, ld_wr_id, iss_dst_id, q0_id, q1_id, qd_id;
  logic [15:0] alu_wr_data, ld_data;
  logic [7:0]  alu_fmask, alu_fdata;
  logic        alu_stall, ld_ready, hazard;
  logic [4:0]  Wr_id;
  logic [15:0] Wr_data;
  logic [7:0]  Fmask, F_data;
`ifdef WB_STATS_EN
  logic [47:0] DEBUG_WB_stats;
`endif

  int n_cmp = 0;
  int n_err = 0;

  rf_writeback #(.LD_FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .alu_valid(alu_valid), .alu_wr_id(alu_wr_id), .alu_wr_data(alu_wr_data),
    .alu_fmask(alu_fmask), .alu_fdata(alu_fdata), .alu_stall(alu_stall),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wr_id(ld_wr_id), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_dst_id(iss_dst_id),
    .q0_id(q0_id), .q1_id(q1_id), .qd_id(qd_id), .hazard(hazard),
    .Wr_id(Wr_id), .Wr_data(Wr_data), .Fmask(Fmask), .F_data(F_data)
`ifdef WB_STATS_EN
    , .DEBUG_WB_stats(DEBUG_WB_stats)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; alu_valid = 0; ld_valid = 0; iss_valid = 0;
    alu_wr_id = ID_R0; ld_wr_id = ID_R0; iss_dst_id = ID_R0;
    q0_id = ID_R0; q1_id = ID_R0; qd_id = ID_R0;
    alu_wr_data = 0; ld_data = 0; alu_fmask = 0; alu_fdata = 0;
    tick(); tick();
    check("rst_ld_ready", ld_ready, 0);
    check("rst_alu_stall", alu_stall, 0);
    check("rst_wr_id", Wr_id, ID_R0);
    check("rst_wr_data", Wr_data, 0);
    check("rst_fmask", Fmask, 0);
    check("rst_fdata", F_data, 0);
    check("rst_hazard", hazard, 0);
    RST_N = 1'b1;
    #1 check("rel_ld_ready", ld_ready, 1);

    // ALU only
    alu_valid = 1; alu_wr_id = ID_HL; alu_wr_data = 16'h1234; alu_fmask = 8'hFF; alu_fdata = 8'h41;
    #1 check("alu_stall0", alu_stall, 0);
    tick();
    alu_valid = 0; alu_fmask = 0; alu_fdata = 0;
    check("alu_wr_id", Wr_id, ID_HL);
    check("alu_wr_data", Wr_data, 16'h1234);
    check("alu_fmask", Fmask, 8'hFF);
    check("alu_fdata", F_data, 8'h41);

    // Load bypass
    ld_valid = 1; ld_wr_id = ID_A; ld_data = 16'h00C3;
    tick();
    ld_valid = 0;
    check("byp_wr_id", Wr_id, ID_A);
    check("byp_data", Wr_data[7:0], 8'hC3);
    check("byp_fmask", Fmask, 0);
    tick();
    check("idle_wr_id", Wr_id, ID_R0);
    check("idle_fmask", Fmask, 0);

    // Starvation: load queued under ALU, 4 more ALU writes, stall, load, ALU resumes
    alu_valid = 1; alu_wr_id = ID_B; alu_wr_data = 16'd0; alu_fmask = 8'h0F;
    ld_valid = 1; ld_wr_id = ID_C; ld_data = 16'h0055;
    tick();
    ld_valid = 0;
    check("stv_first_alu", Wr_id, ID_B);
    for (int k = 1; k <= 4; k++) begin
      alu_wr_data = 16'(k);
      #1 check("stv_no_stall", alu_stall, 0);
      tick();
      check("stv_alu_data", Wr_data, k);
    end
    #1 check("stv_stall", alu_stall, 1);
    tick();
    check("stv_ld_id", Wr_id, ID_C);
    check("stv_ld_data", Wr_data, 16'h0055);
    check("stv_ld_fmask", Fmask, 0);
    alu_wr_data = 16'h00AA;
    #1 check("stv_resume_stall", alu_stall, 0);
    tick();
    check("stv_resume_id", Wr_id, ID_B);
    check("stv_resume_data", Wr_data, 16'h00AA);

    // Full buffer under continuous ALU
    ld_valid = 1; ld_wr_id = ID_D; ld_data = 16'h0011;
    tick();
    ld_wr_id = ID_E; ld_data = 16'h0022;
    tick();
    ld_wr_id = ID_H; ld_data = 16'h0033;
    for (int k = 0; k < 3; k++) begin
      #1 check("full_ready0", ld_ready, 0);
      check("full_stall0", alu_stall, 0);
      tick();
      check("full_alu_id", Wr_id, ID_B);
    end
    #1 check("full_ready_stall", ld_ready, 0);
    check("full_stall1", alu_stall, 1);
    tick();
    check("full_deq_id", Wr_id, ID_D);
    check("full_deq_data", Wr_data, 16'h0011);
    #1 check("full_ready1", ld_ready, 1);
    tick();
    ld_valid = 0;
    check("full_alu_after", Wr_id, ID_B);
    alu_valid = 0;
    tick();
    check("full_e_id", Wr_id, ID_E);
    check("full_e_data", Wr_data, 16'h0022);
    tick();
    check("full_h_id", Wr_id, ID_H);
    check("full_h_data", Wr_data, 16'h0033);
    tick();
    check("full_idle", Wr_id, ID_R0);

    // Scoreboard
    iss_valid = 1; iss_dst_id = ID_BC;
    tick();
    iss_valid = 0;
    q0_id = ID_C; #1 check("sb_c", hazard, 1);
    q0_id = ID_B; #1 check("sb_b", hazard, 1);
    q0_id = ID_D; #1 check("sb_d", hazard, 0);
    q0_id = ID_R0; qd_id = ID_B; #1 check("sb_qd_b", hazard, 1);
    qd_id = ID_R0; q1_id = ID_HL; #1 check("sb_q1_hl", hazard, 0);
    q1_id = ID_R0; q0_id = ID_C;
    ld_valid = 1; ld_wr_id = ID_BC; ld_data = 16'hBEEF;
    tick();
    ld_valid = 0;
    check("sb_ld_id", Wr_id, ID_BC);
    check("sb_ld_data", Wr_data, 16'hBEEF);
    check("sb_cleared", hazard, 0);

    // Reset mid-operation
    alu_valid = 1; alu_wr_id = ID_B;
    ld_valid = 1; ld_wr_id = ID_D; ld_data = 16'h0077;
    iss_valid = 1; iss_dst_id = ID_BC;
    tick();
    iss_valid = 0; ld_wr_id = ID_E; ld_data = 16'h0088;
    tick();
    #1 check("mid_busy", hazard, 1);
    check("mid_full", ld_ready, 0);
    alu_valid = 0; ld_valid = 0;
    RST_N = 0;
    tick();
    RST_N = 1;
    #1 check("mid_wr_id", Wr_id, ID_R0);
    check("mid_hazard", hazard, 0);
    check("mid_ld_ready", ld_ready, 1);
    tick();
    check("mid_no_stale1", Wr_id, ID_R0);
    tick();
    check("mid_no_stale2", Wr_id, ID_R0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
